// File: rtl/ex_sched.sv
// ex_sched: shares one execute datapath between two issue ports.
//
// Two requesters present operation bundles with valid/ready handshakes. A
// round-robin arbiter selects one per cycle and drives its bundle to the
// shared EX unit. The EX unit's combinational result is captured into a
// one-entry output register, tagged with the winning port and its request tag.
//
// Optional feature: define EX_SCHED_PERF_EN to build saturating performance
// counters. Without it the perf_* outputs are tied to zero and perf_clr is
// ignored.
//
// Ports
//   clock, reset_n            clock (rising edge), asynchronous active-low reset
//   req{0,1}_valid/_ready     request handshake per issue port
//   req{0,1}_op, req{0,1}_tag operation bundle and tag per issue port
//   ex_op                     bundle driven to the shared EX unit (zero if idle)
//   ex_result, ex_inval       combinational EX result for ex_op
//   rsp_valid/_ready          registered response handshake
//   rsp_port, rsp_tag         issuing port and its tag
//   rsp_result, rsp_inval     registered ex_result / ex_inval
//   perf_clr                  synchronous clear of the perf counters
//   perf_grant0/1             accepted transfers per port
//   perf_conflict             cycles with a valid request left unaccepted

module ex_sched #(
    parameter int unsigned OP_W  = 140,
    parameter int unsigned TAG_W = 6,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [TAG_W-1:0] req1_tag,

    output logic [OP_W-1:0]  ex_op,
    input  logic [31:0]      ex_result,
    input  logic             ex_inval,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_port,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_result,
    output logic             rsp_inval,

    input  logic             perf_clr,
    output logic [CNT_W-1:0] perf_grant0,
    output logic [CNT_W-1:0] perf_grant1,
    output logic [CNT_W-1:0] perf_conflict
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             rsp_valid_q,  rsp_valid_d;
    logic             rsp_port_q,   rsp_port_d;
    logic [TAG_W-1:0] rsp_tag_q,    rsp_tag_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic             rsp_inval_q,  rsp_inval_d;
    // Port that won the most recent transfer; the other port wins a tie.
    logic             last_grant_q, last_grant_d;

    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             xfer0;
    logic             xfer1;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // The output register can take new data when empty or when it drains
    // in this same cycle.
    assign can_accept = ~rsp_valid_q | rsp_ready;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case ({req1_valid, req0_valid})
            2'b01:   grant0 = 1'b1;
            2'b10:   grant1 = 1'b1;
            2'b11: begin
                if (last_grant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign req0_ready = grant0 & can_accept;
    assign req1_ready = grant1 & can_accept;

    assign xfer0 = req0_valid & req0_ready;
    assign xfer1 = req1_valid & req1_ready;

    // The EX unit sees the granted op even while stalled; its result is only
    // captured on a transfer.
    always_comb begin
        ex_op = '0;
        if (grant1) begin
            ex_op = req1_op;
        end else if (grant0) begin
            ex_op = req0_op;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_port_d   = rsp_port_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_result_d = rsp_result_q;
        rsp_inval_d  = rsp_inval_q;
        last_grant_d = last_grant_q;

        if (xfer0 | xfer1) begin
            rsp_valid_d  = 1'b1;
            rsp_port_d   = xfer1;
            rsp_tag_d    = xfer1 ? req1_tag : req0_tag;
            rsp_result_d = ex_result;
            rsp_inval_d  = ex_inval;
            last_grant_d = xfer1;
        end else if (rsp_ready) begin
            // Drained with nothing new: data fields keep their stale values.
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_port_q   <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_result_q <= '0;
            rsp_inval_q  <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_port_q   <= rsp_port_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_result_q <= rsp_result_d;
            rsp_inval_q  <= rsp_inval_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_port   = rsp_port_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_result = rsp_result_q;
    assign rsp_inval  = rsp_inval_q;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef EX_SCHED_PERF_EN
    logic [CNT_W-1:0] perf_grant0_q,   perf_grant0_d;
    logic [CNT_W-1:0] perf_grant1_q,   perf_grant1_d;
    logic [CNT_W-1:0] perf_conflict_q, perf_conflict_d;
    logic             conflict;

    assign conflict = (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready);

    // Counters saturate at all-ones; clear wins over increment.
    always_comb begin
        perf_grant0_d   = perf_grant0_q;
        perf_grant1_d   = perf_grant1_q;
        perf_conflict_d = perf_conflict_q;
        if (perf_clr) begin
            perf_grant0_d   = '0;
            perf_grant1_d   = '0;
            perf_conflict_d = '0;
        end else begin
            if (xfer0 && (perf_grant0_q != {CNT_W{1'b1}})) begin
                perf_grant0_d = perf_grant0_q + CNT_W'(1);
            end
            if (xfer1 && (perf_grant1_q != {CNT_W{1'b1}})) begin
                perf_grant1_d = perf_grant1_q + CNT_W'(1);
            end
            if (conflict && (perf_conflict_q != {CNT_W{1'b1}})) begin
                perf_conflict_d = perf_conflict_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_grant0_q   <= '0;
            perf_grant1_q   <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_grant0_q   <= perf_grant0_d;
            perf_grant1_q   <= perf_grant1_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_grant0   = perf_grant0_q;
    assign perf_grant1   = perf_grant1_q;
    assign perf_conflict = perf_conflict_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;

    assign perf_grant0   = '0;
    assign perf_grant1   = '0;
    assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_ex_sched.sv
// Testbench for ex_sched: directed vector table, reset/perf sequences and a
// randomized run checked against a transaction-level reference model.
// Works with EX_SCHED_PERF_EN either defined or undefined.

module tb_ex_sched;

    localparam int OP_W    = 140;
    localparam int TAG_W   = 6;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_SUB  = 4'd1;
    localparam logic [3:0] F_AND  = 4'd2;
    localparam logic [3:0] F_OR   = 4'd3;
    localparam logic [3:0] F_XOR  = 4'd4;
    localparam logic [3:0] F_SLL  = 4'd5;
    localparam logic [3:0] F_MOVZ = 4'd6;
    localparam logic [3:0] F_MOVN = 4'd7;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [OP_W-1:0]  req0_op = '0, req1_op = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic [OP_W-1:0]  ex_op;
    logic [31:0]      ex_result;
    logic             ex_inval;
    logic             rsp_valid, rsp_port, rsp_inval;
    logic             rsp_ready = 1'b0;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_result;
    logic             perf_clr = 1'b0;
    logic [CNT_W-1:0] perf_grant0, perf_grant1, perf_conflict;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    ex_sched #(.OP_W(OP_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_tag(req1_tag),
        .ex_op(ex_op), .ex_result(ex_result), .ex_inval(ex_inval),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port),
        .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_inval(rsp_inval),
        .perf_clr(perf_clr), .perf_grant0(perf_grant0),
        .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
    );

    // Bundle layout used by this bench: [3:0] fn, [35:4] A, [67:36] B.
    function automatic logic [32:0] ex_eval(input logic [OP_W-1:0] op);
        logic [31:0] a;
        logic [31:0] b;
        a = op[35:4];
        b = op[67:36];
        case (op[3:0])
            F_ADD:   return {1'b0, a + b};
            F_SUB:   return {1'b0, a - b};
            F_AND:   return {1'b0, a & b};
            F_OR:    return {1'b0, a | b};
            F_XOR:   return {1'b0, a ^ b};
            F_SLL:   return {1'b0, a << b[4:0]};
            F_MOVZ:  return {(b != 32'd0), a};
            F_MOVN:  return {(b == 32'd0), a};
            default: return 33'd0;
        endcase
    endfunction

    // Shared EX unit stand-in.
    logic [32:0] ex_out;
    assign ex_out    = ex_eval(ex_op);
    assign ex_result = ex_out[31:0];
    assign ex_inval  = ex_out[32];

    function automatic logic [OP_W-1:0] mkop(input logic [3:0] fn, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [OP_W-1:0] op;
        op = '0;
        op[3:0]   = fn;
        op[35:4]  = a;
        op[67:36] = b;
        return op;
    endfunction

    function automatic logic [OP_W-1:0] randop();
        logic [159:0] raw;
        logic [OP_W-1:0] op;
        for (int k = 0; k < 5; k++) raw[k*32 +: 32] = $urandom;
        op = raw[OP_W-1:0];
        op[3:0] = 4'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0) op[67:36] = '0;
        return op;
    endfunction

    task automatic chk(input string nm, input logic [OP_W-1:0] act,
                       input logic [OP_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic            v0;
        logic [OP_W-1:0] op0;
        logic [5:0]      t0;
        logic            v1;
        logic [OP_W-1:0] op1;
        logic [5:0]      t1;
        logic            rr;
        logic            e_r0;
        logic            e_r1;
        logic            e_v;
        logic            e_p;
        logic [5:0]      e_t;
        logic [31:0]     e_res;
        logic            e_inv;
    } vec_t;

    function automatic vec_t mkrow(
        input logic v0, input logic [OP_W-1:0] op0, input int t0,
        input logic v1, input logic [OP_W-1:0] op1, input int t1, input logic rr,
        input logic e_r0, input logic e_r1, input logic e_v, input logic e_p,
        input int e_t, input int e_res, input logic e_inv);
        vec_t r;
        r.v0 = v0; r.op0 = op0; r.t0 = 6'(t0);
        r.v1 = v1; r.op1 = op1; r.t1 = 6'(t1); r.rr = rr;
        r.e_r0 = e_r0; r.e_r1 = e_r1; r.e_v = e_v; r.e_p = e_p;
        r.e_t = 6'(e_t); r.e_res = 32'(e_res); r.e_inv = e_inv;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        perf_clr   = 1'b0;
        rsp_ready  = 1'b0;
        reset_n    = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    vec_t tbl[15];

    // Reference model state
    logic            m_v, m_p, m_inv, m_last;
    logic [5:0]      m_t;
    logic [31:0]     m_res;
    int              m_g0, m_g1, m_cf;

    initial begin
        logic [OP_W-1:0] o_add34, o_add11, o_sub, o_xor, o_and, o_or, o_sll;
        logic [OP_W-1:0] o_movz1, o_movz0, z;
        logic held0, held1, e_r0, e_r1, room, conflict;
        int win;
        logic [32:0] r;
        logic [OP_W-1:0] exp_op;

        z       = '0;
        o_add34 = mkop(F_ADD, 3, 4);
        o_add11 = mkop(F_ADD, 1, 1);
        o_sub   = mkop(F_SUB, 10, 3);
        o_xor   = mkop(F_XOR, 6, 3);
        o_and   = mkop(F_AND, 12, 10);
        o_or    = mkop(F_OR, 1, 2);
        o_sll   = mkop(F_SLL, 1, 4);
        o_movz1 = mkop(F_MOVZ, 9, 1);
        o_movz0 = mkop(F_MOVZ, 9, 0);

        //              v0 op0      t0 v1 op1      t1 rr  r0 r1 v  p  tag res inv
        tbl[0]  = mkrow(1, o_add34, 5, 0, z,       0, 1,  1, 0, 0, 0, 0, 0,  0);
        tbl[1]  = mkrow(0, z,       0, 0, z,       0, 1,  0, 0, 1, 0, 5, 7,  0);
        tbl[2]  = mkrow(1, o_add11, 1, 1, o_sub,   2, 1,  0, 1, 0, 0, 0, 0,  0);
        tbl[3]  = mkrow(1, o_add11, 1, 1, o_xor,   3, 1,  1, 0, 1, 1, 2, 7,  0);
        tbl[4]  = mkrow(1, o_and,   4, 1, o_xor,   3, 1,  0, 1, 1, 0, 1, 2,  0);
        tbl[5]  = mkrow(1, o_and,   4, 1, o_or,    6, 1,  1, 0, 1, 1, 3, 5,  0);
        tbl[6]  = mkrow(1, o_sll,   9, 1, o_or,    6, 0,  0, 0, 1, 0, 4, 8,  0);
        tbl[7]  = mkrow(1, o_sll,   9, 1, o_or,    6, 0,  0, 0, 1, 0, 4, 8,  0);
        tbl[8]  = mkrow(1, o_sll,   9, 1, o_or,    6, 0,  0, 0, 1, 0, 4, 8,  0);
        tbl[9]  = mkrow(1, o_sll,   9, 1, o_or,    6, 1,  0, 1, 1, 0, 4, 8,  0);
        tbl[10] = mkrow(1, o_sll,   9, 0, z,       0, 1,  1, 0, 1, 1, 6, 3,  0);
        tbl[11] = mkrow(0, z,       0, 1, o_movz1, 7, 1,  0, 1, 1, 0, 9, 16, 0);
        tbl[12] = mkrow(0, z,       0, 1, o_movz0, 8, 1,  0, 1, 1, 1, 7, 9,  1);
        tbl[13] = mkrow(0, z,       0, 0, z,       0, 1,  0, 0, 1, 1, 8, 9,  0);
        tbl[14] = mkrow(0, z,       0, 0, z,       0, 1,  0, 0, 0, 0, 0, 0,  0);

        // ---------------- reset state ----------------
        next_cycle();
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_port", rsp_port, 0);
        chk("reset rsp_tag", rsp_tag, 0);
        chk("reset rsp_result", rsp_result, 0);
        chk("reset rsp_inval", rsp_inval, 0);
        chk("reset perf_grant0", perf_grant0, 0);
        chk("reset perf_conflict", perf_conflict, 0);
        do_reset();

        // ---------------- directed table ----------------
        for (int i = 0; i < 15; i++) begin
            req0_valid = tbl[i].v0; req0_op = tbl[i].op0; req0_tag = tbl[i].t0;
            req1_valid = tbl[i].v1; req1_op = tbl[i].op1; req1_tag = tbl[i].t1;
            rsp_ready  = tbl[i].rr;
            @(negedge clock);
            chk($sformatf("vec%0d req0_ready", i), req0_ready, tbl[i].e_r0);
            chk($sformatf("vec%0d req1_ready", i), req1_ready, tbl[i].e_r1);
            chk($sformatf("vec%0d rsp_valid", i), rsp_valid, tbl[i].e_v);
            if (tbl[i].e_v) begin
                chk($sformatf("vec%0d rsp_port", i), rsp_port, tbl[i].e_p);
                chk($sformatf("vec%0d rsp_tag", i), rsp_tag, tbl[i].e_t);
                chk($sformatf("vec%0d rsp_result", i), rsp_result, tbl[i].e_res);
                chk($sformatf("vec%0d rsp_inval", i), rsp_inval, tbl[i].e_inv);
            end
            next_cycle();
        end

        // ---------------- asynchronous reset with a held result ----------------
        req0_valid = 1'b1; req0_op = o_add34; req0_tag = 6'd12; rsp_ready = 1'b0;
        next_cycle();
        req0_valid = 1'b0;
        chk("arst pre rsp_valid", rsp_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst rsp_valid", rsp_valid, 0);
        chk("arst rsp_tag", rsp_tag, 0);
        next_cycle();
        reset_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clock);
        chk("arst tie req0_ready", req0_ready, 1);
        chk("arst tie req1_ready", req1_ready, 0);
        next_cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        next_cycle();

        // ---------------- perf counters ----------------
        perf_clr = 1'b1;
        next_cycle();
        perf_clr = 1'b0;
        req0_valid = 1'b1; rsp_ready = 1'b1;
        repeat (5) next_cycle();
        req0_valid = 1'b0;
        @(negedge clock);
`ifdef EX_SCHED_PERF_EN
        chk("perf_grant0 saturated", perf_grant0, CNT_MAX);
`else
        chk("perf_grant0 tied", perf_grant0, 0);
`endif
        next_cycle();
        perf_clr = 1'b1;
        next_cycle();
        perf_clr = 1'b0;
        @(negedge clock);
        chk("perf_clr grant0", perf_grant0, 0);
        chk("perf_clr conflict", perf_conflict, 0);
        next_cycle();
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) next_cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clock);
`ifdef EX_SCHED_PERF_EN
        chk("perf_conflict tie", perf_conflict, 2);
        chk("perf_grant1 tie", perf_grant1, 1);
`else
        chk("perf_conflict tied", perf_conflict, 0);
        chk("perf_grant1 tied", perf_grant1, 0);
`endif
        next_cycle();

        // ---------------- randomized run vs reference model ----------------
        do_reset();
        m_v = 0; m_p = 0; m_inv = 0; m_last = 1; m_t = '0; m_res = '0;
        m_g0 = 0; m_g1 = 0; m_cf = 0;
        held0 = 0; held1 = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            // Requesters hold an unaccepted request unchanged.
            if (!held0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_op    = randop();
                req0_tag   = 6'($urandom);
            end
            if (!held1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_op    = randop();
                req1_tag   = 6'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            perf_clr  = ($urandom_range(0, 40) == 0);
            @(negedge clock);

            if (req0_valid && req1_valid) win = m_last ? 0 : 1;
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
            else                          win = -1;
            room = !m_v || rsp_ready;
            e_r0 = (win == 0) && room;
            e_r1 = (win == 1) && room;
            exp_op = (win == 0) ? req0_op : ((win == 1) ? req1_op : '0);

            chk("rnd req0_ready", req0_ready, e_r0);
            chk("rnd req1_ready", req1_ready, e_r1);
            chk("rnd ex_op", ex_op, exp_op);
            chk("rnd rsp_valid", rsp_valid, m_v);
            if (m_v) begin
                chk("rnd rsp_port", rsp_port, m_p);
                chk("rnd rsp_tag", rsp_tag, m_t);
                chk("rnd rsp_result", rsp_result, m_res);
                chk("rnd rsp_inval", rsp_inval, m_inv);
            end
`ifdef EX_SCHED_PERF_EN
            chk("rnd perf_grant0", perf_grant0, m_g0);
            chk("rnd perf_grant1", perf_grant1, m_g1);
            chk("rnd perf_conflict", perf_conflict, m_cf);
`else
            chk("rnd perf_grant0", perf_grant0, 0);
            chk("rnd perf_conflict", perf_conflict, 0);
`endif

            conflict = (req0_valid && !e_r0) || (req1_valid && !e_r1);
            if (e_r0 || e_r1) begin
                r = ex_eval(exp_op);
                m_v = 1; m_p = (win == 1); m_last = (win == 1);
                m_t = (win == 1) ? req1_tag : req0_tag;
                m_res = r[31:0]; m_inv = r[32];
            end else if (rsp_ready) begin
                m_v = 0;
            end
            if (perf_clr) begin
                m_g0 = 0; m_g1 = 0; m_cf = 0;
            end else begin
                if (e_r0 && m_g0 < CNT_MAX) m_g0++;
                if (e_r1 && m_g1 < CNT_MAX) m_g1++;
                if (conflict && m_cf < CNT_MAX) m_cf++;
            end
            held0 = req0_valid && !e_r0;
            held1 = req1_valid && !e_r1;
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
